// File: rtl/vermibus_sram_bridge.sv
// Valid/ready word-bus slave driving a synchronous SRAM with one-cycle enable and fixed read latency.
// Optional bounds checking of the upper address bits: define VERMIBUS_SRAM_BOUNDS_CHECK_EN.
module vermibus_sram_bridge #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    output logic              ready,
    input  logic [31:0]       address,
    input  logic [3:0]        wstrobe,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              bus_error
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t     state;
    logic [2:0] lat_cnt;

    // Byte-offset bits never reach the SRAM; the upper bits only matter when bounds checking.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

`ifdef VERMIBUS_SRAM_BOUNDS_CHECK_EN
    logic out_of_range;
    assign out_of_range = (address[31:ADDR_W+2] != '0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata      <= '0;
            bus_error  <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            ready   <= 1'b0;
            sram_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
`ifdef VERMIBUS_SRAM_BOUNDS_CHECK_EN
                        if (out_of_range) begin
                            ready     <= 1'b1;
                            bus_error <= 1'b1;
                            if (wstrobe == 4'b0000) rdata <= '0;
                            state     <= RESP;
                        end else
`endif
                        begin
                            sram_addr  <= address[ADDR_W+1:2];
                            sram_we    <= wstrobe;
                            sram_wdata <= wdata;
                            sram_en    <= 1'b1;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // sram_we still holds the latched strobe here and tells read from write.
                    sram_we <= '0;
                    if (sram_we != 4'b0000) begin
                        ready <= 1'b1;
                        state <= RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // At least one WAIT cycle: the SRAM's data arrives READ_LATENCY cycles after its enable edge.
                    if (lat_cnt == 3'd0) begin
                        rdata <= sram_rdata;
                        ready <= 1'b1;
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
